// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, word-length codes, oversample/half-bit tick counts.
// Also holds the frame helpers (parity bit, stop length in ticks) used when a frame is loaded.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        WLS_5 = 2'd0,
        WLS_6 = 2'd1,
        WLS_7 = 2'd2,
        WLS_8 = 2'd3
    } wls_t;

    localparam logic [4:0] OS_TICKS_16   = 5'd16;
    localparam logic [4:0] OS_TICKS_13   = 5'd13;
    localparam logic [4:0] HALF_TICKS_16 = 5'd8;
    localparam logic [4:0] HALF_TICKS_13 = 5'd7;

    // Stop length in sample ticks: 1 bit, 2 bits, or 1.5 bits for 5-bit words.
    function automatic logic [5:0] stop_ticks(input logic stb, input logic [1:0] wls, input logic osm);
        logic [5:0] full_bit;
        logic [5:0] half_bit;
        full_bit = {1'b0, (osm ? OS_TICKS_13 : OS_TICKS_16)};
        half_bit = {1'b0, (osm ? HALF_TICKS_13 : HALF_TICKS_16)};
        if (!stb)
            return full_bit;
        else if (wls == WLS_5)
            return full_bit + half_bit;
        return full_bit + full_bit;
    endfunction

    function automatic logic tx_parity(input logic [7:0] dat, input logic [1:0] wls,
                                       input logic eps, input logic sp);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - wls);
        if (sp)
            return ~eps;
        return (^(dat & mask)) ^ ~eps;
    endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Register-block <-> transmit-core bundle: THR write strobe, line/baud controls, buffer status back.
// master = register block side, slave = transmit core side.
interface uart_tx_core_if #(
    parameter int FIFO_DEPTH = 16,
    parameter int DLR_WIDTH  = 16
);
    logic [7:0]                     thr_in;
    logic                           thr_wr_in;
    logic [1:0]                     wls_in;
    logic                           stb_in;
    logic                           pen_in;
    logic                           eps_in;
    logic                           sp_in;
    logic                           bc_in;
    logic [DLR_WIDTH-1:0]           dlr_in;
    logic                           osm_in;
    logic                           fifoen_in;
    logic                           txclr_in;
    logic                           utrst_in;
    logic                           thre_out;
    logic                           temt_out;
    logic [$clog2(FIFO_DEPTH):0]    tx_level_out;
    logic                           tx_ovf_out;

    modport master (
        output thr_in, thr_wr_in, wls_in, stb_in, pen_in, eps_in, sp_in, bc_in,
               dlr_in, osm_in, fifoen_in, txclr_in, utrst_in,
        input  thre_out, temt_out, tx_level_out, tx_ovf_out
    );

    modport slave (
        input  thr_in, thr_wr_in, wls_in, stb_in, pen_in, eps_in, sp_in, bc_in,
               dlr_in, osm_in, fifoen_in, txclr_in, utrst_in,
        output thre_out, temt_out, tx_level_out, tx_ovf_out
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Baud generator: divisor counter makes a sample tick every dlr clocks, oversample counter flags bit end.
// No backpressure; dlr==0 halts both counters. restart zeroes both so a new frame starts on a clean bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DLR_WIDTH = 16
) (
    input  logic                 apb_clk_in,
    input  logic                 apb_rstn_in,
    input  logic                 restart,
    input  logic [DLR_WIDTH-1:0] dlr,
    input  logic                 osm,
    output logic                 tick,
    output logic                 bit_end
);
    logic [DLR_WIDTH-1:0] div_cnt;
    logic [4:0]           os_cnt;
    logic [4:0]           os_len;

    assign os_len  = osm ? OS_TICKS_13 : OS_TICKS_16;
    // >= keeps the counter from running away if the divisor is lowered mid-count.
    assign tick    = (dlr != '0) && (div_cnt >= dlr - DLR_WIDTH'(1));
    assign bit_end = tick && (os_cnt == os_len - 5'd1);

    always_ff @(posedge apb_clk_in) begin
        if (!apb_rstn_in || restart) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= bit_end ? 5'd0 : os_cnt + 5'd1;
        end else if (dlr != '0) begin
            div_cnt <= div_cnt + DLR_WIDTH'(1);
        end
    end
endmodule

// File: rtl/uart_tx_core.sv
// UART transmit core: byte buffer (FIFO when UART_TX_FIFO_EN is defined) feeding the frame FSM; start bit 2 clks after THR write.
// No backpressure: writes to a full buffer are dropped and flagged by a tx_ovf_out pulse.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DLR_WIDTH  = 16
) (
    input  logic          apb_clk_in,
    input  logic          apb_rstn_in,
    uart_tx_core_if.slave bus,
    output logic          txd_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic             rst;
    logic             clr, push_req, push, pop, full, ovf;
    logic [LVL_W-1:0] level;
    logic [7:0]       rd_dat;
    logic             tick, bit_end, stop_done;

    tx_state_t  state;
    logic [7:0] sr;
    logic [2:0] bit_cnt, nbits_m1;
    logic       pen_q, par_q, osm_q;
    logic [5:0] stop_len_q, stop_cnt;
    logic       line_r, brk_r, thre_r, temt_r, ovf_r;

    assign rst = !apb_rstn_in || !bus.utrst_in;

`ifdef UART_TX_FIFO_EN
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             fifoen_q;

    // Any change of FIFO mode flushes, so the depth switch never strands entries.
    assign clr    = bus.txclr_in || (bus.fifoen_in != fifoen_q);
    assign full   = bus.fifoen_in ? (level == LVL_W'(FIFO_DEPTH)) : (level != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge apb_clk_in) begin
        fifoen_q <= bus.fifoen_in;
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge apb_clk_in) begin
        if (push) mem[wr_ptr] <= bus.thr_in;
    end
`else
    logic [7:0] hold_q;
    logic       unused_fifoen;

    assign unused_fifoen = bus.fifoen_in;
    assign clr    = bus.txclr_in;
    assign full   = (level != '0);
    assign rd_dat = hold_q;

    always_ff @(posedge apb_clk_in) begin
        if (push) hold_q <= bus.thr_in;
    end
`endif

    // A pop in the same cycle frees a slot, so a write to a full buffer is still taken.
    assign stop_done = (state == ST_STOP) && tick && (stop_cnt == stop_len_q - 6'd1);
    assign pop       = (level != '0) && !clr &&
                       (((state == ST_IDLE) && (bus.dlr_in != '0)) || stop_done);
    assign push_req  = bus.thr_wr_in && !clr;
    assign push      = push_req && (!full || pop);
    assign ovf       = push_req && full && !pop;

    always_ff @(posedge apb_clk_in) begin
        if (rst || clr)
            level <= '0;
        else
            level <= level + LVL_W'(push) - LVL_W'(pop);
    end

    uart_baud_gen #(.DLR_WIDTH(DLR_WIDTH)) u_baud (
        .apb_clk_in  (apb_clk_in),
        .apb_rstn_in (!rst),
        .restart     (pop),
        .dlr         (bus.dlr_in),
        .osm         (osm_q),
        .tick        (tick),
        .bit_end     (bit_end)
    );

    always_ff @(posedge apb_clk_in) begin
        if (rst) begin
            state      <= ST_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            nbits_m1   <= 3'd7;
            pen_q      <= 1'b0;
            par_q      <= 1'b0;
            osm_q      <= 1'b0;
            stop_len_q <= 6'd16;
            stop_cnt   <= '0;
            line_r     <= 1'b1;
            brk_r      <= 1'b0;
            thre_r     <= 1'b1;
            temt_r     <= 1'b1;
            ovf_r      <= 1'b0;
        end else begin
            brk_r  <= bus.bc_in;
            thre_r <= (level == '0);
            temt_r <= (level == '0) && (state == ST_IDLE);
            ovf_r  <= ovf;
            if (pop) begin
                // Frame controls are captured here so register writes cannot corrupt a frame in flight.
                state      <= ST_START;
                line_r     <= 1'b0;
                sr         <= rd_dat;
                bit_cnt    <= '0;
                nbits_m1   <= 3'(bus.wls_in) + 3'd4;
                pen_q      <= bus.pen_in;
                par_q      <= tx_parity(rd_dat, bus.wls_in, bus.eps_in, bus.sp_in);
                osm_q      <= bus.osm_in;
                stop_len_q <= stop_ticks(bus.stb_in, bus.wls_in, bus.osm_in);
                stop_cnt   <= '0;
            end else begin
                case (state)
                    ST_START: if (bit_end) begin
                        state  <= ST_DATA;
                        line_r <= sr[0];
                    end
                    ST_DATA: if (bit_end) begin
                        if (bit_cnt == nbits_m1) begin
                            state  <= pen_q ? ST_PARITY : ST_STOP;
                            line_r <= pen_q ? par_q : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sr      <= {1'b0, sr[7:1]};
                            line_r  <= sr[1];
                        end
                    end
                    ST_PARITY: if (bit_end) begin
                        state  <= ST_STOP;
                        line_r <= 1'b1;
                    end
                    ST_STOP: begin
                        if (tick) stop_cnt <= stop_cnt + 6'd1;
                        if (stop_done) begin
                            state  <= ST_IDLE;
                            line_r <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign txd_out          = line_r && !brk_r;
    assign bus.thre_out     = thre_r;
    assign bus.temt_out     = temt_r;
    assign bus.tx_level_out = level;
    assign bus.tx_ovf_out   = ovf_r;
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frame shapes, back-to-back, break, buffer full/clear, transmitter reset.
module tb_uart_tx_core;
`ifdef UART_TX_FIFO_EN
    localparam int EFF_DEPTH = 16;
`else
    localparam int EFF_DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rstn;
    logic txd;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    uart_tx_core_if #(.FIFO_DEPTH(16), .DLR_WIDTH(16)) bus ();

    uart_tx_core #(.FIFO_DEPTH(16), .DLR_WIDTH(16)) dut (
        .apb_clk_in  (clk),
        .apb_rstn_in (rstn),
        .bus         (bus),
        .txd_out     (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        bus.thr_in    = b;
        bus.thr_wr_in = 1'b1;
        step();
        bus.thr_wr_in = 1'b0;
    endtask

    task automatic cfg(input logic [15:0] dlr, input logic osm, input logic [1:0] wls,
                       input logic stb, input logic pen, input logic eps, input logic sp);
        bus.dlr_in = dlr;
        bus.osm_in = osm;
        bus.wls_in = wls;
        bus.stb_in = stb;
        bus.pen_in = pen;
        bus.eps_in = eps;
        bus.sp_in  = sp;
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (txd !== 1'b0 && k < 12) begin
            step();
            k++;
        end
        chk({tag, " start"}, 32'(txd), 0);
    endtask

    // bits[i] is the expected line level of bit i; the last bit lasts last_clks clocks.
    task automatic run_frame(input string tag, input logic [31:0] bits, input int nb,
                             input int cpb, input int last_clks);
        int len;
        int good;
        wait_start(tag);
        for (int i = 0; i < nb; i++) begin
            len  = (i == nb - 1) ? last_clks : cpb;
            good = 0;
            for (int j = 0; j < len; j++) begin
                if (txd === bits[i]) good++;
                step();
            end
            chk($sformatf("%s bit%0d", tag, i), 32'(good), 32'(len));
        end
        chk({tag, " idle"}, 32'(txd), 1);
        step();
        chk({tag, " temt"}, 32'(bus.temt_out), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ovf_seen;
        int good;
        rstn          = 1'b0;
        bus.thr_in    = 8'h00;
        bus.thr_wr_in = 1'b0;
        bus.bc_in     = 1'b0;
        bus.fifoen_in = 1'b1;
        bus.txclr_in  = 1'b0;
        bus.utrst_in  = 1'b1;
        cfg(16'd1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        chk("rst txd",   32'(txd), 1);
        chk("rst thre",  32'(bus.thre_out), 1);
        chk("rst temt",  32'(bus.temt_out), 1);
        chk("rst level", 32'(bus.tx_level_out), 0);
        chk("rst ovf",   32'(bus.tx_ovf_out), 0);
        rstn = 1'b1;
        repeat (2) step();

        // 8N1 0x55 at 16 clks/bit
        wr(8'h55);
        run_frame("8n1", {22'b0, 1'b1, 8'h55, 1'b0}, 10, 16, 16);

        // 7E1 0x41, 13x oversampling, divisor 2: parity bit 0
        cfg(16'd2, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        wr(8'h41);
        run_frame("7e1", {22'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, 26, 26);

        // 5 bits, 1.5 stop bits = 24 clks
        cfg(16'd1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        wr(8'h1F);
        run_frame("5n15", {25'b0, 1'b1, 5'h1F, 1'b0}, 7, 16, 24);

        // back-to-back frames, no idle gap
        cfg(16'd1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(8'hA5);
        wr(8'h3C);
        run_frame("b2b", {12'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 20, 16, 16);

        // break mid-frame; frame length unaffected
        wr(8'hFF);
        wait_start("brk");
        repeat (36) step();
        bus.bc_in = 1'b1;
        step();
        chk("brk low", 32'(txd), 0);
        repeat (9) step();
        chk("brk hold", 32'(txd), 0);
        bus.bc_in = 1'b0;
        step();
        chk("brk release", 32'(txd), 1);
        repeat (112) step();
        chk("brk stop", 32'(txd), 1);
        chk("brk temt busy", 32'(bus.temt_out), 0);
        repeat (2) step();
        chk("brk temt done", 32'(bus.temt_out), 1);

        // buffer fill with baud halted
        cfg(16'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        ovf_seen = 0;
        for (int i = 0; i <= EFF_DEPTH; i++) begin
            wr(8'(i + 1));
            if (bus.tx_ovf_out === 1'b1) ovf_seen++;
        end
        chk("full level", 32'(bus.tx_level_out), 32'(EFF_DEPTH));
        chk("ovf pulses", 32'(ovf_seen), 1);
        step();
        chk("ovf cleared", 32'(bus.tx_ovf_out), 0);
        chk("full thre", 32'(bus.thre_out), 0);
        chk("full temt", 32'(bus.temt_out), 0);
        chk("frozen txd", 32'(txd), 1);
        bus.txclr_in = 1'b1;
        step();
        bus.txclr_in = 1'b0;
        chk("clr level", 32'(bus.tx_level_out), 0);
        step();
        chk("clr thre", 32'(bus.thre_out), 1);
        bus.txclr_in  = 1'b1;
        bus.thr_in    = 8'h99;
        bus.thr_wr_in = 1'b1;
        step();
        bus.txclr_in  = 1'b0;
        bus.thr_wr_in = 1'b0;
        chk("clr+wr level", 32'(bus.tx_level_out), 0);
        chk("clr+wr ovf", 32'(bus.tx_ovf_out), 0);

        // transmitter reset during data bit 3, second byte queued
        cfg(16'd1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(8'h00);
        wr(8'h00);
        wait_start("utrst");
        repeat (69) step();
        chk("utrst pre txd", 32'(txd), 0);
        chk("utrst pre level", 32'(bus.tx_level_out), 1);
        bus.utrst_in = 1'b0;
        step();
        chk("utrst txd", 32'(txd), 1);
        chk("utrst temt", 32'(bus.temt_out), 1);
        chk("utrst level", 32'(bus.tx_level_out), 0);
        bus.utrst_in = 1'b1;
        good = 0;
        for (int j = 0; j < 40; j++) begin
            if (txd === 1'b1) good++;
            step();
        end
        chk("utrst idle", 32'(good), 40);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
